// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and data width.
package load_store_unit_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RESP = 2'd3
   } state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response channel plus word-wide data-memory port of the load/store unit.
interface load_store_unit_if #(
   parameter int ADDR_W = 6
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [31:0]       mem_rdata;

   // The unit itself: serves pipeline requests and drives the memory strobes.
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  resp_ready, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_addr, mem_wdata, mem_we, mem_re
   );

   // The surrounding pipeline stage and data memory.
   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output resp_ready, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane logic: sub-word load extraction with sign/zero extension, and store merge
// of new lanes into a previously read word (little-endian, lane 0 = bits [7:0]).
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [DATA_W-1:0] word_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [1:0]        off_i,
   input  logic [1:0]        size_i,
   input  logic              uns_i,
   output logic [DATA_W-1:0] load_o,
   output logic [DATA_W-1:0] merge_o
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{off_i, 3'b000} +: 8];
      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
      case (size_i)
         SZ_BYTE: load_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_o = {{16{~uns_i & half_sel[15]}}, half_sel};
         default: load_o = word_i;
      endcase
   end

   // Each lane either keeps the read word or takes the matching slice of store data.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic       hit;
         logic [7:0] src;
         assign hit = (size_i == SZ_WORD)
                    | ((size_i == SZ_HALF) & (off_i[1] == LANE[1]))
                    | ((size_i == SZ_BYTE) & (off_i == LANE));
         assign src = (size_i == SZ_WORD) ? wdata_i[8*gi +: 8]
                    : (size_i == SZ_HALF) ? (LANE[0] ? wdata_i[15:8] : wdata_i[7:0])
                    : wdata_i[7:0];
         assign merge_o[8*gi +: 8] = hit ? src : word_i[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-only data memory; sub-word stores use
// read-modify-write. Define LSU_BOUNDS_CHECK_EN to flag addresses beyond the memory as errors.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave bus
);
   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [ADDR_W+1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic                err_q, err_d;
   logic                oob;
   logic                req_err;
   logic [DATA_W-1:0]   load_data;
   logic [DATA_W-1:0]   merge_data;

`ifdef LSU_BOUNDS_CHECK_EN
   assign oob = |bus.req_addr[31:ADDR_W+2];
`else
   logic unused_upper;
   assign oob          = 1'b0;
   assign unused_upper = ^bus.req_addr[31:ADDR_W+2];
`endif

   // Size is checked first, then alignment, then range.
   assign req_err = (bus.req_size == 2'b11)
                  | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
                  | ((bus.req_size == SZ_WORD) & (bus.req_addr[1:0] != 2'b00))
                  | oob;

   lsu_lane_align u_align (
      .word_i  (word_q),
      .wdata_i (wdata_q),
      .off_i   (addr_q[1:0]),
      .size_i  (size_q),
      .uns_i   (uns_q),
      .load_o  (load_data),
      .merge_o (merge_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               addr_d  = bus.req_addr[ADDR_W+1:0];
               wdata_d = bus.req_wdata;
               err_d   = req_err;
               if (req_err)
                  state_d = S_RESP;
               else if (bus.req_we && bus.req_size == SZ_WORD)
                  state_d = S_WR;
               else
                  state_d = S_RD;
            end
         end
         S_RD: begin
            word_d  = bus.mem_rdata;
            state_d = we_q ? S_WR : S_RESP;
         end
         S_WR:    state_d = S_RESP;
         default: if (bus.resp_ready) state_d = S_IDLE;
      endcase
   end

   // Outputs depend only on state and the latched request.
   always_comb begin
      bus.req_ready  = (state_q == S_IDLE);
      bus.mem_re     = (state_q == S_RD);
      bus.mem_we     = (state_q == S_WR);
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      bus.resp_valid = (state_q == S_RESP);
      bus.resp_err   = (state_q == S_RESP) & err_q;
      bus.resp_rdata = '0;
      if (state_q == S_RD || state_q == S_WR)
         bus.mem_addr = addr_q[ADDR_W+1:2];
      if (state_q == S_WR)
         bus.mem_wdata = merge_data;
      if (state_q == S_RESP && !err_q && !we_q)
         bus.resp_rdata = load_data;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, multi-cycle corner
// sequences, and randomized requests against a byte-arithmetic reference model.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   localparam int AW = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   load_store_unit_if #(.ADDR_W(AW)) bus ();

   load_store_unit #(.ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Data memory: combinational read, write on the clock edge; backdoor port for preload.
   logic [31:0] tb_mem [64];
   logic        bk_we;
   logic [5:0]  bk_addr;
   logic [31:0] bk_data;
   always @(posedge clk) begin
      if (bk_we)
         tb_mem[bk_addr] <= bk_data;
      else if (bus.mem_we)
         tb_mem[bus.mem_addr] <= bus.mem_wdata;
   end
   assign bus.mem_rdata = tb_mem[bus.mem_addr];

   int         re_cnt = 0;
   int         we_cnt = 0;
   int         both_cnt = 0;
   logic [5:0] last_addr = '0;
   always @(negedge clk) begin
      if (bus.mem_re) begin
         re_cnt++;
         last_addr = bus.mem_addr;
      end
      if (bus.mem_we) begin
         we_cnt++;
         last_addr = bus.mem_addr;
      end
      if (bus.mem_re && bus.mem_we) both_cnt++;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference memory and model: plain word/byte arithmetic on the byte address.
   logic [31:0] ref_mem [64];

   function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int lat,
                                 output int nre, output int nwe);
      int unsigned widx, off;
      logic [31:0] w, v, m;
      widx = (addr / 4) % 64;
      off  = addr % 4;
      err  = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
`ifdef LSU_BOUNDS_CHECK_EN
      if ((addr / 256) != 0) err = 1'b1;
`endif
      rdata = 32'h0;
      lat = 1; nre = 0; nwe = 0;
      if (err) return;
      w = ref_mem[widx];
      if (!we) begin
         nre = 1; lat = 2;
         if (size == 2'd0) begin
            v = (w >> (8 * off)) & 32'd255;
            if (!uns && v >= 32'd128) v = v - 32'd256;
         end else if (size == 2'd1) begin
            v = (w >> (8 * off)) & 32'd65535;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
         end else begin
            v = w;
         end
         rdata = v;
      end else if (size == 2'd2) begin
         nwe = 1; lat = 2;
         ref_mem[widx] = wdata;
      end else begin
         nre = 1; nwe = 1; lat = 3;
         m = (size == 2'd0) ? 32'd255 : 32'd65535;
         ref_mem[widx] = (w & ~(m << (8 * off))) | ((wdata & m) << (8 * off));
      end
   endfunction

   // One complete request/response transaction with resp_ready held high.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nre, output int nwe, output logic [5:0] maddr);
      int re0, we0;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      re0 = re_cnt;
      we0 = we_cnt;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      rdata = bus.resp_rdata;
      err   = bus.resp_err;
      @(posedge clk);
      #1;
      nre   = re_cnt - re0;
      nwe   = we_cnt - we0;
      maddr = last_addr;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   initial begin
      logic [31:0] rd, m_rd, held;
      logic        er, m_er;
      int          lat, nre, nwe, m_lat, m_nre, m_nwe, re0, we0, unstable, wait_cnt;
      logic [5:0]  maddr;
      logic        r_we, r_uns;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wdata;

      vecs[0]  = '{1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0,        32'h8899AABB, 1'b0, 2};
      vecs[1]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0E, 32'h0,        32'hFFFFFF99, 1'b0, 2};
      vecs[2]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0E, 32'h0,        32'h00000099, 1'b0, 2};
      vecs[3]  = '{1'b0, SZ_HALF, 1'b0, 32'h0E, 32'h0,        32'hFFFF8899, 1'b0, 2};
      vecs[4]  = '{1'b0, SZ_HALF, 1'b1, 32'h0C, 32'h0,        32'h0000AABB, 1'b0, 2};
      vecs[5]  = '{1'b1, SZ_BYTE, 1'b0, 32'h0D, 32'hFFFFFF5A, 32'h0,        1'b0, 3};
      vecs[6]  = '{1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0,        32'h88995ABB, 1'b0, 2};
      vecs[7]  = '{1'b0, SZ_HALF, 1'b0, 32'h0B, 32'h0,        32'h0,        1'b1, 1};
      vecs[8]  = '{1'b0, 2'b11,   1'b0, 32'h0C, 32'h0,        32'h0,        1'b1, 1};
      vecs[9]  = '{1'b0, SZ_WORD, 1'b0, 32'h0E, 32'h0,        32'h0,        1'b1, 1};
      vecs[10] = '{1'b1, SZ_HALF, 1'b0, 32'h0E, 32'h1234CDEF, 32'h0,        1'b0, 3};
      vecs[11] = '{1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0,        32'hCDEF5ABB, 1'b0, 2};
      vecs[12] = '{1'b1, SZ_WORD, 1'b0, 32'h0C, 32'hDEADBEEF, 32'h0,        1'b0, 2};
      vecs[13] = '{1'b0, SZ_BYTE, 1'b0, 32'h0F, 32'h0,        32'hFFFFFFDE, 1'b0, 2};
      vecs[14] = '{1'b0, SZ_BYTE, 1'b0, 32'h0C, 32'h0,        32'hFFFFFFEF, 1'b0, 2};
`ifdef LSU_BOUNDS_CHECK_EN
      vecs[15] = '{1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0,       32'h0,        1'b1, 1};
`else
      vecs[15] = '{1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0,       32'h11223344, 1'b0, 2};
`endif
      vecs[16] = '{1'b1, SZ_HALF, 1'b0, 32'h0D, 32'h0000FFFF, 32'h0,        1'b1, 1};

      // Reset with memory preload.
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_BYTE;
      bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.resp_ready = 1'b1;
      bk_we = 1'b1; bk_addr = '0; bk_data = '0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         bk_addr = 6'(i);
         bk_data = (i == 3) ? 32'h8899AABB : 32'h11223344 + 32'(i) * 32'h01010101;
         ref_mem[i] = bk_data;
      end
      @(negedge clk);
      bk_we = 1'b0;
      check("reset req_ready",  32'(bus.req_ready),  32'h1);
      check("reset resp_valid", 32'(bus.resp_valid), 32'h0);
      check("reset resp_err",   32'(bus.resp_err),   32'h0);
      check("reset mem_re_we",  {30'h0, bus.mem_re, bus.mem_we}, 32'h0);
      check("reset mem_addr",   32'(bus.mem_addr),   32'h0);
      check("reset mem_wdata",  bus.mem_wdata,       32'h0);
      check("reset resp_rdata", bus.resp_rdata,      32'h0);
      rst = 1'b0;

      // Directed vector table.
      for (int i = 0; i < NV; i++) begin
         model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
               m_rd, m_er, m_lat, m_nre, m_nwe);
         issue(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
               rd, er, lat, nre, nwe, maddr);
         $display("[TB] vec %0d we=%0b size=%0d uns=%0b addr=%h -> rdata=%h err=%0b lat=%0d re=%0d we=%0d",
                  i, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, rd, er, lat, nre, nwe);
         check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d re_count", i), 32'(nre),
               (vecs[i].exp_err || (vecs[i].we && vecs[i].size == SZ_WORD)) ? 32'd0 : 32'd1);
         check($sformatf("vec%0d we_count", i), 32'(nwe),
               (vecs[i].exp_err || !vecs[i].we) ? 32'd0 : 32'd1);
         if (!vecs[i].exp_err)
            check($sformatf("vec%0d mem_addr", i), 32'(maddr), (vecs[i].addr / 4) % 64);
      end

      // Response held for 5 cycles while resp_ready is low.
      model(1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0, m_rd, m_er, m_lat, m_nre, m_nwe);
      bus.resp_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = SZ_WORD; bus.req_addr = 32'h0C;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      wait_cnt = 0;
      while (!bus.resp_valid && wait_cnt < 20) begin
         @(posedge clk);
         #1 wait_cnt++;
      end
      held = bus.resp_rdata;
      check("stall first rdata", held, m_rd);
      unstable = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         if (!bus.resp_valid || bus.resp_rdata !== held || bus.req_ready) unstable++;
      end
      $display("[TB] stall rdata=%h unstable_cycles=%0d", held, unstable);
      check("stall stable", 32'(unstable), 32'd0);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 check("stall release", {30'h0, bus.resp_valid, bus.req_ready}, 32'h1);

      // Reset during the read phase of a sub-word store: access must be abandoned.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_BYTE;
      bus.req_addr = 32'h11; bus.req_wdata = 32'h000000AA;
      we0 = we_cnt; re0 = re_cnt;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      check("mid-RD mem_re", 32'(bus.mem_re), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post-reset state", {28'h0, bus.req_ready, bus.mem_re, bus.mem_we, bus.resp_valid},
            32'h8);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      $display("[TB] reset mid-RD: extra reads=%0d writes=%0d resp_valid=%0b",
               re_cnt - re0, we_cnt - we0, bus.resp_valid);
      check("abandoned write", 32'(we_cnt - we0), 32'd0);
      check("dropped response", 32'(bus.resp_valid), 32'd0);
      model(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, m_rd, m_er, m_lat, m_nre, m_nwe);
      issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat, nre, nwe, maddr);
      check("word4 untouched", rd, m_rd);

      // Randomized requests against the reference model.
      for (int t = 0; t < 80; t++) begin
         r_we    = 1'($urandom_range(0, 1));
         r_size  = 2'($urandom_range(0, 3));
         r_uns   = 1'($urandom_range(0, 1));
         r_addr  = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 5) == 0) r_addr = r_addr | (32'($urandom_range(1, 255)) << 8);
         r_wdata = $urandom;
         model(r_we, r_size, r_uns, r_addr, r_wdata, m_rd, m_er, m_lat, m_nre, m_nwe);
         issue(r_we, r_size, r_uns, r_addr, r_wdata, rd, er, lat, nre, nwe, maddr);
         $display("[TB] rnd %0d we=%0b size=%0d uns=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                  t, r_we, r_size, r_uns, r_addr, r_wdata, rd, er, lat);
         check($sformatf("rnd%0d rdata", t), rd, m_rd);
         check($sformatf("rnd%0d err", t), 32'(er), 32'(m_er));
         check($sformatf("rnd%0d latency", t), 32'(lat), 32'(m_lat));
         check($sformatf("rnd%0d strobes", t), 32'(nre * 2 + nwe), 32'(m_nre * 2 + m_nwe));
      end

      check("re/we never together", 32'(both_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
